// File: rtl/julia_pkg.sv
// Shared types and default parameters for the Julia-set iteration controller.
package julia_pkg;

  // Default escape threshold on |w|^2: 4.0 with both components scaled by 1000.
  localparam logic signed [31:0] ESC_LIMIT_DEF = 32'sd4000000;
  // Default iteration counter width.
  localparam int ITER_W_DEF = 16;
  // Default number of WAIT cycles tolerated before declaring the step unit dead.
  localparam int WD_LIMIT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT,
    EVAL,
    DONE
  } state_t;

endpackage

// File: rtl/julia_iter_ctrl_if.sv
// Bus between the iteration controller and the single-step calculation unit.
interface julia_iter_ctrl_if;
  logic               step_en;
  logic signed [31:0] step_x;
  logic signed [31:0] step_y;
  logic signed [31:0] step_cr;
  logic signed [31:0] step_ci;
  logic               step_end;
  logic signed [31:0] step_wx;
  logic signed [31:0] step_wy;
  logic signed [31:0] step_res;

  // Controller side: issues operands, consumes results.
  modport master (
    output step_en, step_x, step_y, step_cr, step_ci,
    input  step_end, step_wx, step_wy, step_res
  );

  // Step unit side.
  modport slave (
    input  step_en, step_x, step_y, step_cr, step_ci,
    output step_end, step_wx, step_wy, step_res
  );
endinterface

// File: rtl/julia_escape_chk.sv
// Combinational escape test on the squared magnitude from the step unit.
module julia_escape_chk (
  input  logic signed [31:0] res,
  input  logic signed [31:0] limit,
  output logic               escape
);
  // A negative result can only come from an overflowed square sum, so it
  // counts as an escape as well.
  assign escape = (res > limit) || res[31];
endmodule

// File: rtl/julia_iter_ctrl.sv
// Per-pixel Julia iteration controller: sequences a single-step unit,
// counts iterations, detects escape and guards the step unit with a watchdog.
module julia_iter_ctrl
  import julia_pkg::*;
#(
  parameter logic signed [31:0] ESC_LIMIT = ESC_LIMIT_DEF,
  parameter int                 ITER_W    = ITER_W_DEF,
  parameter int                 WD_LIMIT  = WD_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [31:0]   in_x,
  input  logic signed [31:0]   in_y,
  input  logic signed [31:0]   cr,
  input  logic signed [31:0]   ci,
  input  logic [ITER_W-1:0]    max_iter,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic [ITER_W-1:0]    iter_count,
  output logic                 escaped,
  output logic                 wd_error,
  julia_iter_ctrl_if.master    step
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);

  state_t state_reg, state_next;

  logic               busy_reg, busy_next;
  logic               result_valid_reg, result_valid_next;
  logic [ITER_W-1:0]  iter_count_reg, iter_count_next;
  logic [ITER_W-1:0]  max_iter_reg, max_iter_next;
  logic               escaped_reg, escaped_next;
  logic               wd_error_reg, wd_error_next;
  logic               step_en_reg, step_en_next;
  logic signed [31:0] step_x_reg, step_x_next;
  logic signed [31:0] step_y_reg, step_y_next;
  logic signed [31:0] step_cr_reg, step_cr_next;
  logic signed [31:0] step_ci_reg, step_ci_next;
  logic signed [31:0] wx_cap_reg, wx_cap_next;
  logic signed [31:0] wy_cap_reg, wy_cap_next;
  logic signed [31:0] res_cap_reg, res_cap_next;
  logic [WD_W-1:0]    wd_cnt_reg, wd_cnt_next;

  logic              escape;
  logic [ITER_W-1:0] iter_inc;
  logic              last_iter;
  logic              wd_expired;

  julia_escape_chk u_escape_chk (
    .res    (res_cap_reg),
    .limit  (ESC_LIMIT),
    .escape (escape)
  );

  // iter_count < max_iter whenever EVAL is reached, so the increment never wraps.
  assign iter_inc   = iter_count_reg + 1'b1;
  assign last_iter  = (iter_inc == max_iter_reg);
  // The current WAIT cycle is the WD_LIMIT-th one without a step_end.
  assign wd_expired = (wd_cnt_reg == WD_W'(WD_LIMIT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (max_iter == '0) ? DONE : RUN;
      RUN:  state_next = WAIT;
      WAIT: begin
        if (step.step_end)   state_next = EVAL;
        else if (wd_expired) state_next = DONE;
      end
      EVAL: state_next = (escape || last_iter) ? DONE : RUN;
      DONE: if (result_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    busy_next         = busy_reg;
    result_valid_next = result_valid_reg;
    iter_count_next   = iter_count_reg;
    max_iter_next     = max_iter_reg;
    escaped_next      = escaped_reg;
    wd_error_next     = wd_error_reg;
    step_en_next      = step_en_reg;
    step_x_next       = step_x_reg;
    step_y_next       = step_y_reg;
    step_cr_next      = step_cr_reg;
    step_ci_next      = step_ci_reg;
    wx_cap_next       = wx_cap_reg;
    wy_cap_next       = wy_cap_reg;
    res_cap_next      = res_cap_reg;
    wd_cnt_next       = wd_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          step_x_next     = in_x;
          step_y_next     = in_y;
          step_cr_next    = cr;
          step_ci_next    = ci;
          max_iter_next   = max_iter;
          iter_count_next = '0;
          escaped_next    = 1'b0;
          wd_error_next   = 1'b0;
          // A zero cap finishes immediately without issuing any step.
          if (max_iter == '0) begin
            busy_next         = 1'b0;
            result_valid_next = 1'b1;
          end else begin
            busy_next = 1'b1;
          end
        end
      end
      RUN: begin
        step_en_next = 1'b1;
        wd_cnt_next  = '0;
      end
      WAIT: begin
        if (step.step_end) begin
          wx_cap_next  = step.step_wx;
          wy_cap_next  = step.step_wy;
          res_cap_next = step.step_res;
          step_en_next = 1'b0;
        end else if (wd_expired) begin
          wd_error_next     = 1'b1;
          step_en_next      = 1'b0;
          busy_next         = 1'b0;
          result_valid_next = 1'b1;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      EVAL: begin
        // step_en stays low through EVAL and RUN so the step unit rearms.
        step_en_next    = 1'b0;
        iter_count_next = iter_inc;
        if (escape || last_iter) begin
          escaped_next      = escape;
          busy_next         = 1'b0;
          result_valid_next = 1'b1;
        end else begin
          step_x_next = wx_cap_reg;
          step_y_next = wy_cap_reg;
        end
      end
      DONE: begin
        if (result_ack) result_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg         <= 1'b0;
      result_valid_reg <= 1'b0;
      iter_count_reg   <= '0;
      max_iter_reg     <= '0;
      escaped_reg      <= 1'b0;
      wd_error_reg     <= 1'b0;
      step_en_reg      <= 1'b0;
      step_x_reg       <= '0;
      step_y_reg       <= '0;
      step_cr_reg      <= '0;
      step_ci_reg      <= '0;
      wx_cap_reg       <= '0;
      wy_cap_reg       <= '0;
      res_cap_reg      <= '0;
      wd_cnt_reg       <= '0;
    end else begin
      busy_reg         <= busy_next;
      result_valid_reg <= result_valid_next;
      iter_count_reg   <= iter_count_next;
      max_iter_reg     <= max_iter_next;
      escaped_reg      <= escaped_next;
      wd_error_reg     <= wd_error_next;
      step_en_reg      <= step_en_next;
      step_x_reg       <= step_x_next;
      step_y_reg       <= step_y_next;
      step_cr_reg      <= step_cr_next;
      step_ci_reg      <= step_ci_next;
      wx_cap_reg       <= wx_cap_next;
      wy_cap_reg       <= wy_cap_next;
      res_cap_reg      <= res_cap_next;
      wd_cnt_reg       <= wd_cnt_next;
    end
  end

  assign busy         = busy_reg;
  assign result_valid = result_valid_reg;
  assign iter_count   = iter_count_reg;
  assign escaped      = escaped_reg;
  assign wd_error     = wd_error_reg;
  assign step.step_en = step_en_reg;
  assign step.step_x  = step_x_reg;
  assign step.step_y  = step_y_reg;
  assign step.step_cr = step_cr_reg;
  assign step.step_ci = step_ci_reg;

endmodule

// File: tb/tb_julia_iter_ctrl.sv
// Directed bench for julia_iter_ctrl with a one-cycle step unit stub.
module tb_julia_iter_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [31:0] in_x = '0, in_y = '0, cr = '0, ci = '0;
  logic [15:0]        max_iter = '0;
  logic               busy, result_valid, escaped, wd_error;
  logic               result_ack = 1'b0;
  logic [15:0]        iter_count;
  logic               stub_dead = 1'b0;
  logic               stub_fired;

  int checks = 0;
  int errors = 0;

  julia_iter_ctrl_if sif ();

  julia_iter_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_x         (in_x),
    .in_y         (in_y),
    .cr           (cr),
    .ci           (ci),
    .max_iter     (max_iter),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .iter_count   (iter_count),
    .escaped      (escaped),
    .wd_error     (wd_error),
    .step         (sif)
  );

  always #5 clk = ~clk;

  // w = z^2 + c at scale 1000; res = |w|^2 truncated to 32 bits
  function automatic logic [95:0] step_fn(input longint x, input longint y,
                                          input longint a, input longint b);
    longint wx, wy, res;
    wx  = (x * x - y * y) / 1000 + a;
    wy  = (2 * x * y) / 1000 + b;
    res = wx * wx + wy * wy;
    return {wx[31:0], wy[31:0], res[31:0]};
  endfunction

  // Step unit stub: answers one cycle after step_en, rearms when step_en drops
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sif.step_end <= 1'b0;
      sif.step_wx  <= '0;
      sif.step_wy  <= '0;
      sif.step_res <= '0;
      stub_fired   <= 1'b0;
    end else if (!sif.step_en) begin
      sif.step_end <= 1'b0;
      stub_fired   <= 1'b0;
    end else if (!stub_fired && !stub_dead) begin
      {sif.step_wx, sif.step_wy, sif.step_res} <=
        step_fn(sif.step_x, sif.step_y, sif.step_cr, sif.step_ci);
      sif.step_end <= 1'b1;
      stub_fired   <= 1'b1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    x, y, a, b;
    int    mi;
    bit    dead;
    int    exp_iter;
    bit    exp_esc;
    bit    exp_wd;
    int    exp_lat;
    int    exp_rises;
    int    exp_hi;
  } vec_t;

  // Launch one pixel; count cycles until result_valid and step_en activity
  task automatic run_pixel(input int x, input int y, input int a, input int b,
                           input int mi, output int lat, output int rises,
                           output int hi);
    logic prev;
    @(negedge clk);
    in_x = x; in_y = y; cr = a; ci = b; max_iter = 16'(mi); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; rises = 0; hi = 0; prev = 1'b0;
    while (!result_valid && lat < 400) begin
      if (sif.step_en) hi++;
      if (sif.step_en && !prev) rises++;
      prev = sif.step_en;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack_result();
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk("ack_clears_valid", result_valid, 0);
  endtask

  vec_t vecs[9];
  int lat, rises, hi, seen, n;

  initial begin
    vecs[0] = '{"zero_orbit",   0,    0, 0,     0,    50, 1'b0, 50, 1'b0, 1'b0, 201, 50, 100};
    vecs[1] = '{"big_start",    3000, 0, 0,     0,    50, 1'b0, 1,  1'b1, 1'b0, 5,   1,  2};
    vecs[2] = '{"period2_real", 0,    0, -1000, 0,    20, 1'b0, 20, 1'b0, 1'b0, 81,  20, 40};
    vecs[3] = '{"max_iter_0",   0,    0, -1000, 0,    0,  1'b0, 0,  1'b0, 1'b0, 1,   0,  0};
    vecs[4] = '{"max_iter_1",   0,    0, -1000, 0,    1,  1'b0, 1,  1'b0, 1'b0, 5,   1,  2};
    vecs[5] = '{"c_imag_unit",  0,    0, 0,     1000, 10, 1'b0, 10, 1'b0, 1'b0, 41,  10, 20};
    vecs[6] = '{"slow_escape",  0,    0, 500,   0,    50, 1'b0, 5,  1'b1, 1'b0, 21,  5,  10};
    vecs[7] = '{"overflow_neg", 0,    0, 46341, 0,    50, 1'b0, 1,  1'b1, 1'b0, 5,   1,  2};
    vecs[8] = '{"watchdog",     0,    0, 0,     0,    50, 1'b1, 0,  1'b0, 1'b1, 17,  1,  15};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_step_en", sif.step_en, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      stub_dead = vecs[i].dead;
      run_pixel(vecs[i].x, vecs[i].y, vecs[i].a, vecs[i].b, vecs[i].mi, lat, rises, hi);
      $display("pixel %s: iter=%0d esc=%0d wd=%0d lat=%0d steps=%0d",
               vecs[i].name, iter_count, escaped, wd_error, lat, rises);
      chk({vecs[i].name, "_valid"}, result_valid, 1);
      chk({vecs[i].name, "_busy"}, busy, 0);
      chk({vecs[i].name, "_iter"}, iter_count, vecs[i].exp_iter);
      chk({vecs[i].name, "_escaped"}, escaped, vecs[i].exp_esc);
      chk({vecs[i].name, "_wd"}, wd_error, vecs[i].exp_wd);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_step_pulses"}, rises, vecs[i].exp_rises);
      chk({vecs[i].name, "_step_en_cycles"}, hi, vecs[i].exp_hi);
      ack_result();
    end
    stub_dead = 1'b0;

    // Result held stable without ack; start with ack in DONE is ignored
    run_pixel(0, 0, 500, 0, 50, lat, rises, hi);
    repeat (5) @(negedge clk);
    $display("hold: valid=%0d iter=%0d esc=%0d", result_valid, iter_count, escaped);
    chk("hold_valid", result_valid, 1);
    chk("hold_iter", iter_count, 5);
    chk("hold_escaped", escaped, 1);
    result_ack = 1'b1; start = 1'b1; in_x = 3000; max_iter = 16'd50;
    @(negedge clk);
    result_ack = 1'b0; start = 1'b0;
    chk("ack_start_valid", result_valid, 0);
    chk("ack_start_busy", busy, 0);
    @(negedge clk);
    $display("ack+start: busy=%0d valid=%0d", busy, result_valid);
    chk("ack_start_busy_later", busy, 0);

    // start during a running pixel must not disturb it
    @(negedge clk);
    in_x = 0; in_y = 0; cr = -1000; ci = 0; max_iter = 16'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    in_x = 3000; cr = 0; max_iter = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!result_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    $display("start_ignored: iter=%0d esc=%0d", iter_count, escaped);
    chk("start_ignored_timeout", n < 200, 1);
    chk("start_ignored_iter", iter_count, 20);
    chk("start_ignored_esc", escaped, 0);
    ack_result();

    // Reset during WAIT of iteration 3
    @(negedge clk);
    in_x = 0; in_y = 0; cr = 0; ci = 1000; max_iter = 16'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(iter_count == 16'd2 && sif.step_en) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_iter3_wait", n < 100, 1);
    #1 rst = 1'b1;
    #1;
    $display("mid reset: busy=%0d iter=%0d step_en=%0d x=%0d ci=%0d",
             busy, iter_count, sif.step_en, sif.step_x, sif.step_ci);
    chk("midrst_busy", busy, 0);
    chk("midrst_iter", iter_count, 0);
    chk("midrst_step_en", sif.step_en, 0);
    chk("midrst_step_x", sif.step_x, 0);
    chk("midrst_step_ci", sif.step_ci, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (result_valid || busy) seen++;
    end
    chk("midrst_no_result", seen, 0);
    run_pixel(0, 0, -1000, 0, 20, lat, rises, hi);
    $display("after reset: iter=%0d esc=%0d lat=%0d", iter_count, escaped, lat);
    chk("post_rst_valid", result_valid, 1);
    chk("post_rst_iter", iter_count, 20);
    chk("post_rst_esc", escaped, 0);
    ack_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
